// File: rtl/cannon_pkg.sv
// Shared definitions for the Cannon multiplier result path: default matrix
// geometry, the accumulated element width formula and the collector state encoding.
package cannon_pkg;

    localparam int N       = 3;
    localparam int WIDTH   = 16;
    localparam int C_WIDTH = 2 * WIDTH + $clog2(N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } collector_state_t;

endpackage

// File: rtl/cannon_result_collector_if.sv
// Serial result stream between the Cannon multiplier (master) and the
// result collector (slave); the producer advances on any edge with c_valid && c_ready.
interface cannon_result_collector_if #(
    parameter int N     = cannon_pkg::N,
    parameter int WIDTH = cannon_pkg::WIDTH
);

    localparam int C_WIDTH = 2 * WIDTH + $clog2(N);

    logic [C_WIDTH-1:0] c_in;
    logic               c_valid;
    logic               c_ready;

    modport master (
        output c_in,
        output c_valid,
        input  c_ready
    );

    modport slave (
        input  c_in,
        input  c_valid,
        output c_ready
    );

endinterface

// File: rtl/cannon_result_buffer.sv
// N*N frame buffer with one write port and a registered, range-checked read port.
// With COLLECTOR_SHADOW_EN a second bank is added: writes fill the back bank, reads use the front.
module cannon_result_buffer #(
    parameter int DEPTH = 9,
    parameter int AW    = 4,
    parameter int DW    = 34
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          swap,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW:0] DEPTH_V = (AW + 1)'(DEPTH);

    logic rd_in_range;

    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_V);

`ifdef COLLECTOR_SHADOW_EN
    logic [DW-1:0] mem [2][DEPTH];
    logic          bank_sel;

    // The last word of a frame lands in the back bank on the same edge the banks swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[b][i] <= '0;
                end
            end
            bank_sel <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (we) begin
                mem[~bank_sel][waddr] <= wdata;
            end
            if (swap) begin
                bank_sel <= ~bank_sel;
            end
            rd_data <= rd_in_range ? mem[bank_sel][rd_addr] : '0;
        end
    end
`else
    logic [DW-1:0] mem [DEPTH];

    // A read of the word being written on the same edge returns the old contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rd_data <= rd_in_range ? mem[rd_addr] : '0;
        end
    end

    logic unused_swap;
    assign unused_swap = swap;
`endif

endmodule

// File: rtl/cannon_result_collector.sv
// Collects one N*N frame of Cannon results per capture_en into a display buffer.
// Build option COLLECTOR_SHADOW_EN double-buffers the frame so the display never sees a partial one.
module cannon_result_collector #(
    parameter int N              = cannon_pkg::N,
    parameter int WIDTH          = cannon_pkg::WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              capture_en,
    cannon_result_collector_if.slave          stream,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              frame_valid,
    output logic                              timeout_err,
    output logic [7:0]                        frame_count,
    input  logic [$clog2(N*N)-1:0]            rd_addr,
    output logic [2*WIDTH+$clog2(N)-1:0]      rd_data
);

    import cannon_pkg::collector_state_t;
    import cannon_pkg::IDLE;
    import cannon_pkg::COLLECT;
    import cannon_pkg::HOLD;

    localparam int C_WIDTH = 2 * WIDTH + $clog2(N);
    localparam int DEPTH   = N * N;
    localparam int AW      = $clog2(DEPTH);
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW-1:0] LAST_IDX   = AW'(DEPTH - 1);
    localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT_CYCLES - 1);

    collector_state_t state;
    logic [AW-1:0]    idx;
    logic [TW-1:0]    idle_cnt;
    logic             transfer;
    logic             last_transfer;

    // Handshake is decoded from the state register alone so c_valid never loops back into c_ready.
    assign stream.c_ready = (state == COLLECT);
    assign busy           = (state == COLLECT);
    assign transfer       = stream.c_valid && (state == COLLECT);
    assign last_transfer  = transfer && (idx == LAST_IDX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            idle_cnt    <= '0;
            frame_done  <= 1'b0;
            frame_valid <= 1'b0;
            timeout_err <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (capture_en) begin
                        state    <= COLLECT;
                        idx      <= '0;
                        idle_cnt <= '0;
`ifdef COLLECTOR_SHADOW_EN
                        frame_valid <= frame_valid;
`else
                        frame_valid <= 1'b0;
`endif
                    end
                end
                COLLECT: begin
                    if (transfer) begin
                        idle_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state       <= HOLD;
                            idx         <= '0;
                            frame_valid <= 1'b1;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end else if (idle_cnt == IDLE_LIMIT) begin
                        // A stalled producer abandons the frame; frame_valid is left as it was.
                        state       <= IDLE;
                        timeout_err <= 1'b1;
                    end else begin
                        idle_cnt <= idle_cnt + TW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    cannon_result_buffer #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (C_WIDTH)
    ) u_buffer (
        .clk     (clk),
        .reset   (reset),
        .we      (transfer),
        .waddr   (idx),
        .wdata   (stream.c_in),
        .swap    (last_transfer),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: doc/cannon_result_collector.md
# cannon_result_collector

- Consumer end of the Cannon multiplier's serial result stream.
- Drives `read_ready` for the multiplier.
- Accepts the N*N accumulated C elements in row-major order and stores them in a frame buffer.
- Exposes a completed frame through a registered random-access read port for the VGA display path. Frame-complete and error status go to the control logic.

## Interface
Parameters:
- N, 3, matrix dimension; a frame is N*N elements
- WIDTH, 16, A/B element width; C_WIDTH = 2*WIDTH + $clog2(N) (34 at defaults), derived, not overridable
- TIMEOUT_CYCLES, 1024, maximum idle cycles between transfers while collecting

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- capture_en  in  1  one-cycle request to collect one frame
- c_in  in  C_WIDTH  result element (multiplier `serial_c_out`)
- c_valid  in  1  element valid (multiplier `output_valid`)
- c_ready  out  1  collector ready (to multiplier `read_ready`)
- busy  out  1  high while collecting
- frame_done  out  1  one-cycle pulse when the last element of a frame is written
- frame_valid  out  1  level; the buffer holds a complete frame
- timeout_err  out  1  sticky; a collection stalled
- frame_count  out  8  completed frames, wraps 255->0
- rd_addr  in  $clog2(N*N)  display read index, row-major
- rd_data  out  C_WIDTH  buffer word at rd_addr

## Operation
- Transfer: on any rising edge with c_valid && c_ready.
  - The word is written at write index idx.
  - idx increments.
  - The producer advances on the same edge.
- States:
  - IDLE: c_ready=0. capture_en -> COLLECT; set idx=0, clear the idle counter, clear frame_valid.
  - COLLECT: c_ready=1, busy=1.
    - A transfer with idx==N*N-1 -> HOLD. On that edge: set frame_valid, pulse frame_done, increment frame_count.
    - The idle counter increments on each cycle without a transfer and clears on a transfer.
    - When the idle counter reaches TIMEOUT_CYCLES-1 with no transfer -> IDLE. On that edge: set timeout_err, leave frame_valid=0; buffer contents are undefined for display.
  - HOLD: c_ready=0. capture_en -> COLLECT, same actions as from IDLE.
- c_ready and busy are decoded combinationally from the state register only; there is no path from c_valid to c_ready.
- c_valid while c_ready=0 is ignored; no words are dropped or written.
- capture_en while in COLLECT is ignored.
- timeout_err clears only on reset.
- rd_addr >= N*N returns 0.
- Reads during COLLECT return the partially written buffer; consumers gate on frame_valid.
- No arithmetic on data; C_WIDTH words are stored bit-exact.

## Timing
- Reset values:
  - State: IDLE
  - Outputs: c_ready=0, busy=0, frame_done=0, frame_valid=0, timeout_err=0, frame_count=0, rd_data=0
  - Buffer: cleared to 0
- Reset asserted mid-collection aborts immediately: outputs go to their reset values and the partial frame is discarded.
- capture_en at edge t gives c_ready=1 from t+1.
- The first transfer can occur at edge t+1.
- A producer streaming back-to-back completes N*N transfers at edges t+1..t+N*N. frame_done and frame_valid are high after edge t+N*N, and c_ready=0 in the same cycle.
- rd_data is registered: rd_addr sampled at edge t gives rd_data valid after t, one-cycle latency.
- A read of the address being written on the same edge returns the old word.

## Configuration
- COLLECTOR_SHADOW_EN defined:
  - Two banks. Writes go to the back bank; reads come from the front bank.
  - Banks swap on the frame_done edge.
  - frame_valid, once set, stays 1 through later collections and timeouts, so the display never sees a partial frame.
  - A timeout does not swap banks.
- COLLECTOR_SHADOW_EN undefined:
  - Single bank, behaviour exactly as in Operation; frame_valid drops on capture_en.

## Structure
- Shared package cannon_pkg holds N, WIDTH, the C_WIDTH formula, and the collector state encoding (IDLE=0, COLLECT=1, HOLD=2).
- One sub-module, cannon_result_buffer:
  - N*N x C_WIDTH register file with write port, registered read port and out-of-range zeroing.
  - Second bank plus bank-select bit when COLLECTOR_SHADOW_EN is defined.
- FSM, idle counter and status outputs live in the top module.

## Test plan
- Back-to-back stream: after reset, capture_en; producer sends 1..9 with c_valid held high -> rd_addr 0..8 reads 1..9; frame_done pulses once at edge t+9; frame_count=1; c_ready low from t+9.
- Gapped producer: c_valid deasserted 3 cycles between each of 9 words (values 34'h3FFFFFFFF, 0, 5, ...) -> exact words stored; no timeout; idle counter never exceeds 3.
- Backpressure: c_valid high while state is IDLE or HOLD -> no writes; buffer and frame_count unchanged.
- Timeout: TIMEOUT_CYCLES=16; 4 words delivered, then c_valid held low -> return to IDLE after 16 idle cycles; timeout_err=1 and sticky; frame_valid=0; the next capture_en collects normally.
- Reset mid-frame: reset low after 5 transfers -> all outputs and buffer at reset values immediately; after release, capture_en plus 9 words gives the correct frame.
- With COLLECTOR_SHADOW_EN: collect frame A, then start frame B; reads during B return A; rd_data switches to B one cycle after B's frame_done.
